// File: rtl/bit_serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// bit_serial_alu_ctrl
//   Bit-serial ALU controller. An operation is accepted in IDLE, then one
//   result bit per clock is produced LSB first through a single 1-bit ALU
//   slice. A one-cycle done pulse marks the result and flags valid; they
//   hold until the next accepted start.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   reset    : synchronous active-high reset
//   start    : operation request, sampled only in IDLE
//   ctrl     : opcode ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7
//   a, b     : operands, captured when start is accepted
//   busy     : high while the operation is in progress (RUN)
//   done     : one-cycle pulse, result/flags valid
//   result   : operation result
//   carryout : carry out of the MSB (arithmetic ops only)
//   overflow : signed overflow (arithmetic ops only)
//   zero     : result equals zero
// -----------------------------------------------------------------------------
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SLT  = 3'd3,
        OP_AND  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_OR   = 3'd7
    } op_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // 1-bit ALU slice signals
    logic is_arith;
    logic inv_b;
    logic a_bit;
    logic b_bit;
    logic sum_bit;
    logic carry_nxt;
    logic slice_out;
    logic last_bit;
    logic ovf_bit;

    always_comb begin
        is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
        inv_b     = (op_q == OP_SUB) || (op_q == OP_SLT);
        a_bit     = a_q[cnt_q];
        b_bit     = b_q[cnt_q] ^ inv_b;
        sum_bit   = a_bit ^ b_bit ^ carry_q;
        carry_nxt = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
        // Carry into the MSB is carry_q while the last bit is processed.
        ovf_bit   = carry_q ^ carry_nxt;
        last_bit  = (cnt_q == CW'(WIDTH - 1));
        unique case (op_q)
            OP_XOR:  slice_out = a_bit ^ b_bit;
            OP_AND:  slice_out = a_bit & b_bit;
            OP_NAND: slice_out = ~(a_bit & b_bit);
            OP_NOR:  slice_out = ~(a_bit | b_bit);
            OP_OR:   slice_out = a_bit | b_bit;
            default: slice_out = sum_bit;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_t'(ctrl);
                    cnt_d   = '0;
                    carry_d = (op_t'(ctrl) == OP_SUB) || (op_t'(ctrl) == OP_SLT);
                    res_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                end
            end
            RUN: begin
                res_d[cnt_q] = slice_out;
                if (is_arith) begin
                    carry_d = carry_nxt;
                end
                if (last_bit) begin
                    state_d = DONE;
                    cout_d  = is_arith & carry_nxt;
                    ovf_d   = is_arith & ovf_bit;
                    // SLT replaces the accumulated difference with the
                    // sign-corrected comparison bit.
                    if (op_q == OP_SLT) begin
                        res_d    = '0;
                        res_d[0] = sum_bit ^ ovf_bit;
                    end
                    zero_d = (res_d == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = res_q;
    assign carryout = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_alu_ctrl
//   Self-checking bench for bit_serial_alu_ctrl at WIDTH=8: directed vector
//   table, randomized operations against an arithmetic reference model, and
//   hand-written sequences for ignored starts and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_bit_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ctrl     (ctrl),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic co, output logic ov,
                                  output logic z);
        logic [W:0] s;
        co = 1'b0;
        ov = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[W-1:0];
                co = s[W];
                ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd1, 3'd3: begin
                s  = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                co = s[W];
                ov = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
                if (op == 3'd1) r = s[W-1:0];
                else            r = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
            end
            3'd2:    r = x ^ y;
            3'd4:    r = x & y;
            3'd5:    r = ~(x & y);
            3'd6:    r = ~(x | y);
            default: r = x | y;
        endcase
        z = (r == '0);
    endfunction

    // Issue one operation, scramble inputs after capture, wait for done
    // (bounded), then check latency, busy length, pulse width and hold.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input string tag, output logic [W-1:0] r, output logic co,
                          output logic ov, output logic z);
        int lat;
        int busyc;
        @(negedge clk);
        ctrl  = op;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        ctrl  = 3'($urandom);
        lat   = -1;
        busyc = busy ? 1 : 0;
        for (int n = 1; n <= 3 * W && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (done) lat = n;
            else if (busy) busyc++;
        end
        r  = result;
        co = carryout;
        ov = overflow;
        z  = zero;
        chk({tag, " latency"}, lat, W);
        chk({tag, " busy_cycles"}, busyc, W);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, done, 1'b0);
        chk({tag, " hold"}, result, r);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    initial begin
        vec_t         vt[10];
        logic [W-1:0] r, er;
        logic         co, ov, z, eco, eov, ez;
        int           ndone, nbusy;

        vt[0] = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vt[1] = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[2] = '{3'd3, 8'h80, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0};
        vt[3] = '{3'd3, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1};
        vt[4] = '{3'd6, 8'h0F, 8'h33, 8'hC0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{3'd5, 8'h0F, 8'h33, 8'hFC, 1'b0, 1'b0, 1'b0};
        vt[6] = '{3'd7, 8'h0F, 8'h33, 8'h3F, 1'b0, 1'b0, 1'b0};
        vt[7] = '{3'd2, 8'h0F, 8'h33, 8'h3C, 1'b0, 1'b0, 1'b0};
        vt[8] = '{3'd4, 8'h0F, 8'h33, 8'h03, 1'b0, 1'b0, 1'b0};
        vt[9] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};

        reset = 1'b1;
        start = 1'b1;
        ctrl  = 3'd0;
        a     = 8'h11;
        b     = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, '0);
        chk("reset flags", {carryout, overflow, zero}, 3'b000);
        start = 1'b0;
        reset = 1'b0;

        // Directed table
        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].x, vt[i].y, $sformatf("vec%0d", i), r, co, ov, z);
            chk($sformatf("vec%0d result", i), r, vt[i].r);
            chk($sformatf("vec%0d carryout", i), co, vt[i].co);
            chk($sformatf("vec%0d overflow", i), ov, vt[i].ov);
            chk($sformatf("vec%0d zero", i), z, vt[i].z);
        end

        // Randomized against the model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]   op;
            logic [W-1:0] x, y;
            op = 3'($urandom_range(0, 7));
            x  = W'($urandom);
            y  = W'($urandom);
            model(op, x, y, er, eco, eov, ez);
            run_op(op, x, y, $sformatf("rnd%0d", i), r, co, ov, z);
            chk($sformatf("rnd%0d op%0d result", i, op), r, er);
            chk($sformatf("rnd%0d op%0d flags", i, op), {co, ov, z}, {eco, eov, ez});
        end

        // Start re-pulsed during RUN and during DONE must be ignored
        @(negedge clk);
        ctrl  = 3'd0;
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        nbusy = busy ? 1 : 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (busy) nbusy++;
            start = (n == 2) || (n == W);
        end
        start = 1'b0;
        chk("ignored_start done_count", ndone, 1);
        chk("ignored_start busy_cycles", nbusy, W);
        chk("ignored_start result", result, 8'h30);

        // Reset in the middle of a SUB aborts with no done
        @(negedge clk);
        ctrl  = 3'd1;
        a     = 8'h09;
        b     = 8'h03;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort result", result, '0);
        chk("abort flags", {carryout, overflow, zero}, 3'b000);
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
        chk("abort no_done", ndone, 0);
        run_op(3'd0, 8'h01, 8'h01, "post_abort", r, co, ov, z);
        chk("post_abort result", r, 8'h02);
        chk("post_abort flags", {co, ov, z}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
BIT_SERIAL_ALU_CTRL -- requirements
Module: bit_serial_alu_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port ctrl, input, 3 bits: opcode ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (RUN state).
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the result outputs valid.
REQ-009 The block SHALL have port result, output, WIDTH bits: operation result.
REQ-010 The block SHALL have ports carryout, overflow and zero, output, 1 bit each: status flags.

Function
REQ-011 The block SHALL compute one result bit per clock, LSB first, through a single 1-bit ALU slice, with internal registers for operand A, operand B, opcode, result, carry and a bit counter of clog2(WIDTH) bits.
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE -> RUN when start=1: capture a, b and ctrl; clear the bit counter; load carry with 1 for SUB/SLT and 0 otherwise; clear the result register.
REQ-014 In RUN, each edge SHALL process bit[counter]:
- B input is b[i] XOR 1 for SUB/SLT, b[i] otherwise.
- Sum = A^B'^carry; carry <= majority(A, B', carry) for ADD/SUB/SLT.
- Logic ops produce the bitwise function and leave carry unchanged.
REQ-015 RUN -> DONE on the edge that processes bit WIDTH-1; otherwise the counter SHALL increment by 1.
REQ-016 DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-017 Latency: with start accepted at edge k, done SHALL be high exactly in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from start.
REQ-018 carryout SHALL be the carry out of bit WIDTH-1 for ADD/SUB/SLT, and 0 for logic ops.
REQ-019 overflow SHALL be (carry into MSB) XOR (carry out of MSB) for ADD/SUB/SLT, and 0 for logic ops.
REQ-020 For SLT, result SHALL be {WIDTH-1 zeros, MSB_sum XOR overflow}, written on the final RUN edge.
REQ-021 zero SHALL be 1 iff the final result equals 0.
REQ-022 result and all flags SHALL hold their values from DONE until the next accepted start.
REQ-023 start SHALL be ignored in RUN and DONE; an ignored request is not queued.
REQ-024 Changes on a, b or ctrl after capture SHALL NOT affect the operation in progress.

Reset
REQ-025 While reset=1 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, result=0, carryout=0, overflow=0, zero=0, counter=0 and carry=0; reset overrides start.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; reset has priority over all transitions.

Verification (WIDTH=8)
REQ-027 ADD a=0x7F, b=0x01 -> done at cycle 9 after start; result=0x80, overflow=1, carryout=0, zero=0.
REQ-028 SUB a=0x05, b=0x05 -> result=0x00, zero=1, carryout=1, overflow=0.
REQ-029 SLT a=0x80, b=0x01 -> result=0x01; SLT a=0x01, b=0x80 -> result=0x00, zero=1.
REQ-030 NOR a=0x0F, b=0x33 -> result=0xC0, carryout=0, overflow=0; NAND and OR with the same operands -> 0xFC and 0x3F.
REQ-031 start pulsed again at cycles 3 and 9 of a running ADD -> ignored, exactly one done, result unchanged; busy high for exactly 8 cycles.
REQ-032 reset at cycle 4 of a SUB -> next cycle busy=0, result=0, no done; a following ADD 0x01+0x01 -> 0x02.
